// File: rtl/tm_qm_assoc_lookup.sv
// First-level queue-association lookup: issues one table read per enqueue request and
// pairs each in-order read response with its buffered {qid, desc} context.
module tm_qm_assoc_lookup #(
    parameter int unsigned QID_NBITS   = 8,
    parameter int unsigned ASSOC_NBITS = 8,
    parameter int unsigned DESC_NBITS  = 32,
    parameter int unsigned DEPTH_NBITS = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enq_valid,
    input  logic [QID_NBITS-1:0]   enq_qid,
    input  logic [DESC_NBITS-1:0]  enq_desc,
    output logic                   enq_ready,
    output logic                   queue_association_rd,
    output logic [QID_NBITS-1:0]   queue_association_raddr,
    input  logic                   queue_association_ack,
    input  logic [ASSOC_NBITS-1:0] queue_association_rdata,
    output logic                   map_valid,
    output logic [QID_NBITS-1:0]   map_qid,
    output logic [ASSOC_NBITS-1:0] map_assoc,
    output logic [DESC_NBITS-1:0]  map_desc,
    input  logic                   map_ready,
    output logic                   err_unexp_ack
);

    localparam int unsigned DEPTH = 1 << DEPTH_NBITS;
    localparam int unsigned PTR_W = DEPTH_NBITS + 1;
    localparam int unsigned CTX_W = QID_NBITS + DESC_NBITS;

    logic [PTR_W-1:0]       r_credit;
    logic [PTR_W-1:0]       r_pend;
    logic [PTR_W-1:0]       r_ctx_wp;
    logic [PTR_W-1:0]       r_ctx_rp;
    logic [PTR_W-1:0]       r_res_wp;
    logic [PTR_W-1:0]       r_res_rp;
    logic                   r_rd;
    logic [QID_NBITS-1:0]   r_raddr;
    logic                   r_err;
    logic [CTX_W-1:0]       r_ctx_mem [DEPTH];
    logic [ASSOC_NBITS-1:0] r_res_mem [DEPTH];

    logic [PTR_W-1:0]       w_credit_nxt;
    logic [PTR_W-1:0]       w_pend_nxt;
    logic                   w_accept;
    logic                   w_pop;
    logic                   w_ctx_full;
    logic                   w_ctx_wr;
    logic                   w_res_full;
    logic                   w_res_empty;
    logic                   w_ack_ok;
    logic                   w_ack_bad;
    logic [CTX_W-1:0]       w_ctx_head;
    logic [ASSOC_NBITS-1:0] w_res_head;

    // Full/empty by MSB compare on DEPTH_NBITS+1 bit pointers
    assign w_ctx_full  = (r_ctx_wp[PTR_W-1] != r_ctx_rp[PTR_W-1]) &&
                         (r_ctx_wp[DEPTH_NBITS-1:0] == r_ctx_rp[DEPTH_NBITS-1:0]);
    assign w_res_full  = (r_res_wp[PTR_W-1] != r_res_rp[PTR_W-1]) &&
                         (r_res_wp[DEPTH_NBITS-1:0] == r_res_rp[DEPTH_NBITS-1:0]);
    assign w_res_empty = (r_res_wp == r_res_rp);

    assign enq_ready = (r_credit != PTR_W'(DEPTH));
    assign w_accept  = enq_valid & enq_ready;
    assign w_ctx_wr  = w_accept & ~w_ctx_full;
    assign w_pop     = map_valid & map_ready;
    assign w_ack_ok  = queue_association_ack & (r_pend != '0) & ~w_res_full;
    assign w_ack_bad = queue_association_ack & (r_pend == '0);

    assign w_ctx_head = r_ctx_mem[r_ctx_rp[DEPTH_NBITS-1:0]];
    assign w_res_head = r_res_mem[r_res_rp[DEPTH_NBITS-1:0]];

    // Result is valid once its association has returned; context head is always older
    assign map_valid = ~w_res_empty;
    assign map_qid   = map_valid ? w_ctx_head[CTX_W-1 -: QID_NBITS] : '0;
    assign map_desc  = map_valid ? w_ctx_head[DESC_NBITS-1:0] : '0;
    assign map_assoc = map_valid ? w_res_head : '0;

    assign queue_association_rd    = r_rd;
    assign queue_association_raddr = r_raddr;
    assign err_unexp_ack           = r_err;

    // Credit and pending-read counters: simultaneous inc/dec leaves them unchanged
    always_comb begin
        w_credit_nxt = r_credit;
        w_pend_nxt   = r_pend;
        case ({w_accept, w_pop})
            2'b10:   w_credit_nxt = r_credit + PTR_W'(1);
            2'b01:   w_credit_nxt = r_credit - PTR_W'(1);
            default: w_credit_nxt = r_credit;
        endcase
        case ({r_rd, w_ack_ok})
            2'b10:   w_pend_nxt = r_pend + PTR_W'(1);
            2'b01:   w_pend_nxt = r_pend - PTR_W'(1);
            default: w_pend_nxt = r_pend;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credit <= '0;
            r_pend   <= '0;
            r_ctx_wp <= '0;
            r_ctx_rp <= '0;
            r_res_wp <= '0;
            r_res_rp <= '0;
            r_rd     <= 1'b0;
            r_raddr  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_credit <= w_credit_nxt;
            r_pend   <= w_pend_nxt;
            r_rd     <= w_accept;
            if (w_accept) begin
                r_raddr <= enq_qid;
            end
            if (w_ctx_wr) begin
                r_ctx_wp <= r_ctx_wp + PTR_W'(1);
            end
            if (w_ack_ok) begin
                r_res_wp <= r_res_wp + PTR_W'(1);
            end
            if (w_pop) begin
                r_ctx_rp <= r_ctx_rp + PTR_W'(1);
                r_res_rp <= r_res_rp + PTR_W'(1);
            end
            if (w_ack_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    // Storage arrays carry no reset; pointers alone define validity
    always_ff @(posedge clk) begin
        if (w_ctx_wr) begin
            r_ctx_mem[r_ctx_wp[DEPTH_NBITS-1:0]] <= {enq_qid, enq_desc};
        end
        if (w_ack_ok) begin
            r_res_mem[r_res_wp[DEPTH_NBITS-1:0]] <= queue_association_rdata;
        end
    end

endmodule
